// File: rtl/z_tile_writeback_if.sv
// z_tile_writeback_if: external-memory write-burst bus between the tile
// writeback engine (master) and the memory controller (slave).
`default_nettype none

interface z_tile_writeback_if;
   logic [31:0] mem_addr;
   logic [7:0]  mem_burstcnt;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic        mem_waitrequest;

   modport master (
      output mem_addr,
      output mem_burstcnt,
      output mem_wdata,
      output mem_wr,
      input  mem_waitrequest
   );

   modport slave (
      input  mem_addr,
      input  mem_burstcnt,
      input  mem_wdata,
      input  mem_wr,
      output mem_waitrequest
   );
endinterface

`default_nettype wire

// File: rtl/z_tile_writeback.sv
// z_tile_writeback: streams a 32x32 Z tile to memory as 32 row bursts.
// Optional ZWB_CLEAR_AFTER_READ_EN zeroes each tile word once its beat is accepted.
`default_nettype none

module z_tile_writeback #(
   parameter logic [31:0] ROW_STRIDE = 32'd2560
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        base_addr,
   output logic [9:0]         zb_rd_addr,
   input  logic [31:0]        zb_rd_data,
   output logic               zb_clr_we,
   output logic [9:0]         zb_clr_addr,
   z_tile_writeback_if.master mem,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_BURST = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] fifo_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  cnt_q;
   logic        rd_vld_q;
   logic [10:0] rd_idx_q;
   logic [9:0]  rd_addr_q;
   logic [4:0]  row_q;
   logic [4:0]  col_q;
   logic [31:0] addr_q;
   logic        busy_q;
   logic        done_q;

   logic        push;
   logic        pop;
   logic        rd_issue;
   logic [2:0]  occ;

   // rd_vld_q marks the read issued last cycle; its word is on zb_rd_data now.
   assign push = rd_vld_q;
   assign pop  = (cnt_q != 2'd0) && !mem.mem_waitrequest;
   assign occ  = {1'b0, cnt_q} + {2'b00, rd_vld_q};

   // A new read lands one cycle after the in-flight one; only issue if the
   // FIFO still has room for it assuming no pop next cycle.
   assign rd_issue = ((state_q == S_PRIME) || (state_q == S_BURST)) &&
                     !rd_idx_q[10] && (occ <= (3'd1 + {2'b00, pop}));

   assign zb_rd_addr       = rd_issue ? rd_idx_q[9:0] : rd_addr_q;
   assign mem.mem_addr     = addr_q;
   assign mem.mem_burstcnt = 8'd32;
   assign mem.mem_wdata    = fifo_q[rd_ptr_q];
   assign mem.mem_wr       = (cnt_q != 2'd0);
   assign busy             = busy_q;
   assign done             = done_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         fifo_q[0] <= 32'd0;
         fifo_q[1] <= 32'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         rd_vld_q  <= 1'b0;
         rd_idx_q  <= 11'd0;
         rd_addr_q <= 10'd0;
         row_q     <= 5'd0;
         col_q     <= 5'd0;
         addr_q    <= 32'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         if (rd_issue) begin
            rd_addr_q <= rd_idx_q[9:0];
            rd_idx_q  <= rd_idx_q + 11'd1;
         end
         rd_vld_q <= rd_issue;
         if (push) begin
            fifo_q[wr_ptr_q] <= zb_rd_data;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q  <= cnt_q + {1'b0, push} - {1'b0, pop};
         done_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q   <= base_addr;
                  row_q    <= 5'd0;
                  col_q    <= 5'd0;
                  rd_idx_q <= 11'd0;
                  busy_q   <= 1'b1;
                  state_q  <= S_PRIME;
               end
            end
            S_PRIME: begin
               if (push) begin
                  state_q <= S_BURST;
               end
            end
            S_BURST: begin
               if (pop) begin
                  col_q <= col_q + 5'd1;
                  if (col_q == 5'd31) begin
                     row_q <= row_q + 5'd1;
                     if (row_q != 5'd31) begin
                        addr_q <= addr_q + ROW_STRIDE;
                     end
                  end
                  if ((row_q == 5'd31) && (col_q == 5'd31)) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ZWB_CLEAR_AFTER_READ_EN
   logic       clr_we_q;
   logic [9:0] clr_addr_q;

   // Word {row,col} has already left the tile buffer once its beat is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         clr_we_q   <= 1'b0;
         clr_addr_q <= 10'd0;
      end else begin
         clr_we_q <= pop;
         if (pop) begin
            clr_addr_q <= {row_q, col_q};
         end
      end
   end

   assign zb_clr_we   = clr_we_q;
   assign zb_clr_addr = clr_addr_q;
`else
   assign zb_clr_we   = 1'b0;
   assign zb_clr_addr = 10'd0;
`endif

endmodule

`default_nettype wire

// File: doc/z_tile_writeback.md
Z_TILE_WRITEBACK -- requirements
Module: z_tile_writeback

Interface
REQ-001 Parameter: ROW_STRIDE, default 32'd2560, byte distance between successive tile rows in external memory.
REQ-002 Port: clock  input  1  sole clock; all logic rising-edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle pulse; begin tile writeback.
REQ-005 Port: base_addr  input  32  byte address of tile word (0,0); latched on accepted start.
REQ-006 Port: zb_rd_addr  output  10  tile Z-buffer read address, {row[4:0],col[4:0]}.
REQ-007 Port: zb_rd_data  input  32  Z word; valid exactly 1 cycle after zb_rd_addr is presented.
REQ-008 Port: zb_clr_we / zb_clr_addr  output  1 / 10  per-entry zero-write strobe and address for the tile buffer.
REQ-009 Port: mem_addr  output  32  burst start byte address.
REQ-010 Port: mem_burstcnt  output  8  burst length, constant 8'd32.
REQ-011 Port: mem_wdata / mem_wr  output  32 / 1  write beat data and valid.
REQ-012 Port: mem_waitrequest  input  1  beat stalled when high.
REQ-013 Port: busy / done  output  1 / 1  operation in progress; one-cycle completion pulse.

Function
REQ-014 Tile is 32x32 words; each row is one 32-beat burst; 32 bursts per tile; rows in order 0..31, columns 0..31.
REQ-015 Burst r mem_addr = base_addr + r*ROW_STRIDE, 32-bit wrap-around arithmetic; mem_addr held constant for all beats of a burst.
REQ-016 Beat accepted on a cycle with mem_wr=1 and mem_waitrequest=0; mem_wdata/mem_wr/mem_addr SHALL stay stable while mem_waitrequest=1.
REQ-017 FSM states: IDLE, PRIME, BURST, DONE.
REQ-018 IDLE: start=1 -> latch base_addr, row=0, col=0, busy=1, go PRIME; start ignored in all other states.
REQ-019 PRIME: issue read of word 0, fill a 2-entry prefetch FIFO covering RAM latency; go BURST once one entry is valid (2 cycles after start).
REQ-020 BURST: mem_wr=1 whenever FIFO non-empty; reads issued only when FIFO has space accounting for the read in flight; no beat is dropped or duplicated under any waitrequest pattern.
REQ-021 After beat 31 of a row is accepted, next beat belongs to row+1 with new mem_addr; mem_wr may continue back-to-back without a bubble.
REQ-022 After beat 1023 accepted -> DONE: done=1 for exactly one cycle, busy=0 next cycle, return IDLE.
REQ-023 Throughput: with mem_waitrequest held 0, 1024 beats complete in 1024 consecutive cycles after PRIME.
REQ-024 zb_rd_addr holds its last value when not reading.

Reset
REQ-025 reset=1 on a clock edge forces IDLE, FIFO empty, row/col=0, mem_wr=0, zb_clr_we=0, busy=0, done=0, zb_rd_addr=0, mem_addr=0, mem_wdata=0, mem_burstcnt=8'd32.
REQ-026 Reset mid-burst aborts immediately; no done pulse; a partial burst is left incomplete by design.
REQ-027 start coincident with reset is ignored.

Configuration
REQ-028 Macro ZWB_CLEAR_AFTER_READ_EN.
REQ-029 Defined: on each accepted beat, zb_clr_we=1 for one cycle with zb_clr_addr = address of that beat's word, leaving the tile buffer all-zero at done.
REQ-030 Undefined: zb_clr_we constant 0, zb_clr_addr constant 0; tile buffer untouched.

Verification
REQ-031 RAM preloaded word[i]=i, base_addr=32'h0010_0000, waitrequest=0, start pulse -> 32 bursts, burst r addr 32'h0010_0000+r*2560, beat data 0..1023 in order, done 1026 cycles after start.
REQ-032 Same preload, waitrequest pseudo-random 50% -> identical beat sequence 0..1023, mem_wr/mem_addr/mem_wdata stable across every stalled cycle.
REQ-033 base_addr=32'hFFFF_F000 -> burst 2 addr 32'h0000_0400 (wrap), data correct.
REQ-034 reset asserted at beat 500 -> next cycle mem_wr=0, busy=0, no done; new start transfers full tile from word 0.
REQ-035 start pulsed during BURST -> ignored, exactly one done, 1024 beats total.
REQ-036 With ZWB_CLEAR_AFTER_READ_EN: after done, all 1024 RAM words read 0 and zb_clr_we pulsed 1024 times; without it, RAM contents unchanged and zb_clr_we never asserted.
